spm_rr_arbiter: RTL and testbench
=================================

// Module: spm_rr_arbiter
// PURPOSE
//   Shares one single_port_memory instance between NumReq requesters (e.g. DMA loader,
//   compute-core operand fetch, result writeback). Round-robin arbitration grants
//   at most one request per cycle, drives the memory port, and returns registered
//   read data to the requester whose read was accepted. Sits between the requesters
//   and the memory.
// PARAMETERS
//   NumReq    2            number of requesters (>=2)
//   DataWidth 128          memory word width, matches memory DataWidth
//   DataDepth 1024         memory depth, matches memory DataDepth
//   AddrWidth derived      (DataDepth<=1) ? 1 : $clog2(DataDepth)
// PORTS
//   clk_i          in   1                    clock, all logic on posedge
//   rst_ni         in   1                    reset, synchronous, active-low
//   req_valid_i    in   NumReq               per-requester request valid
//   req_ready_o    out  NumReq               per-requester grant; one-hot or zero
//   req_we_i       in   NumReq               1=write, 0=read
//   req_addr_i     in   NumReq*AddrWidth     requester i at [i*AddrWidth +: AddrWidth]
//   req_wdata_i    in   NumReq*DataWidth     requester i at [i*DataWidth +: DataWidth]
//   rsp_valid_o    out  NumReq               read-data-valid pulse, per requester
//   rsp_rdata_o    out  DataWidth            read data, shared, qualified by rsp_valid_o
//   mem_addr_o     out  AddrWidth            to memory address
//   mem_we_o       out  1                    to memory write enable
//   mem_wr_data_o  out  DataWidth            to memory write data
//   mem_rd_data_i  in   DataWidth            from memory, combinational read
// BEHAVIOUR
// - Handshake: transfer on req_valid_i[i] & req_ready_o[i]. Requester holds valid,
//   we, addr, wdata stable until granted. Ready depends on valid (comb.); no
//   valid->ready loop from the requester side is allowed.
// - Arbitration (comb.): prio_q in [0,NumReq-1]. Winner = first i with valid set,
//   scanning prio_q, prio_q+1, ... mod NumReq. req_ready_o = one-hot winner; all
//   zero when no valid.
// - Pointer: on grant to i, prio_q <= (i+1) mod NumReq (wraps NumReq-1 -> 0). No
//   grant: prio_q holds. Fairness: a continuously valid requester waits at most
//   NumReq-1 grants.
// - Memory drive (comb.): granted -> mem_addr_o=winner addr, mem_we_o=winner we,
//   mem_wr_data_o=winner wdata. No grant -> mem_addr_o=0, mem_we_o=0,
//   mem_wr_data_o=0.
// - Read: accepted read at edge N captures mem_rd_data_i into rsp_rdata_o; cycle
//   N+1 has rsp_valid_o[i]=1 (single-cycle pulse). Latency exactly 1 cycle. No
//   response backpressure: requester must consume in that cycle.
// - Write: committed by memory at grant edge; no response pulse. rsp_rdata_o holds
//   last read data during writes/idle.
// - Ordering: one op per cycle, so write at cycle N then read of same addr at N+1
//   returns new data. Grant of a read in the same cycle a response pulses is
//   legal (back-to-back reads, full throughput).
// - Reset (rst_ni=0 at posedge): prio_q=0, rsp_valid_o=0, rsp_rdata_o=0.
//   req_ready_o=0 and mem_we_o=0 while rst_ni=0 (gated comb.); in-flight read
//   response is dropped, nothing written that cycle.
// - Widths: no arithmetic on data; prio_q width $clog2(NumReq) (min 1);
//   increment wraps explicitly, not by overflow, for non-power-of-2 NumReq.
// TESTING
// 1 Reset: rst_ni=0 2 cycles, all valid=1 -> ready=0, mem_we_o=0, rsp_valid=0;
//   first cycle after release grants req0.
// 2 Contention: NumReq=2, both valid reads every cycle -> grants alternate
//   0,1,0,1; each rsp_valid one cycle after its grant with correct data.
// 3 RAW: req0 write addr 5 = 0xA5..A5, next cycle req1 read addr 5 ->
//   rsp_valid_o=2'b10 with rsp_rdata_o=0xA5..A5.
// 4 Wrap/fairness: NumReq=3, all valid for 9 cycles -> grant order 0,1,2,0,1,2,...;
//   only req2 valid after grant to 2 -> grant 2 again (pointer wrapped to 0).
// 5 Idle hold: no valid 5 cycles -> mem_we_o=0, rsp_valid=0, rsp_rdata_o
//   unchanged, next grant follows stored prio_q.
// 6 Reset mid-op: read granted at N, rst_ni=0 at N+1 -> rsp_valid_o=0,
//   rsp_rdata_o=0, prio_q=0.

Source files
------------

// File: rtl/spm_rr_arbiter.sv
// Round-robin arbiter sharing one single-port memory between NumReq requesters.
// Latency: grant is combinational; read data returns exactly 1 cycle after the grant edge.
// Backpressure: at most one request is granted per cycle; responses cannot be stalled.
module spm_rr_arbiter #(
    parameter int NumReq    = 2,
    parameter int DataWidth = 128,
    parameter int DataDepth = 1024,
    parameter int AddrWidth = (DataDepth <= 1) ? 1 : $clog2(DataDepth)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NumReq-1:0]             req_valid_i,
    output logic [NumReq-1:0]             req_ready_o,
    input  logic [NumReq-1:0]             req_we_i,
    input  logic [NumReq*AddrWidth-1:0]   req_addr_i,
    input  logic [NumReq*DataWidth-1:0]   req_wdata_i,
    output logic [NumReq-1:0]             rsp_valid_o,
    output logic [DataWidth-1:0]          rsp_rdata_o,
    output logic [AddrWidth-1:0]          mem_addr_o,
    output logic                          mem_we_o,
    output logic [DataWidth-1:0]          mem_wr_data_o,
    input  logic [DataWidth-1:0]          mem_rd_data_i
);

    localparam int PrioWidth = (NumReq <= 2) ? 1 : $clog2(NumReq);
    localparam logic [PrioWidth-1:0] LastIdx = PrioWidth'(NumReq - 1);
    localparam logic [PrioWidth:0]   NumReqW = (PrioWidth + 1)'(NumReq);

    logic [PrioWidth-1:0] prio_q;
    logic [PrioWidth-1:0] prio_d;
    logic [PrioWidth-1:0] winner;
    logic [PrioWidth:0]   scan_sum;
    logic [2*NumReq-1:0]  rot_valid;
    logic                 found;
    logic                 grant_vld;
    logic                 win_we;
    logic                 rd_grant;
    logic [NumReq-1:0]    rsp_valid_q;
    logic [DataWidth-1:0] rsp_rdata_q;

    // Rotating the doubled valid vector puts the highest-priority requester at bit 0.
    always_comb begin
        rot_valid = {req_valid_i, req_valid_i} >> prio_q;
        found     = 1'b0;
        winner    = '0;
        scan_sum  = '0;
        for (int k = 0; k < NumReq; k++) begin
            if (!found && rot_valid[k]) begin
                found    = 1'b1;
                scan_sum = {1'b0, prio_q} + (PrioWidth + 1)'(k);
                if (scan_sum >= NumReqW) begin
                    scan_sum = scan_sum - NumReqW;
                end
                winner = scan_sum[PrioWidth-1:0];
            end
        end
    end

    assign grant_vld = found & rst_ni;
    assign prio_d    = (winner == LastIdx) ? '0 : winner + PrioWidth'(1);

    always_comb begin
        req_ready_o   = '0;
        mem_addr_o    = '0;
        mem_we_o      = 1'b0;
        mem_wr_data_o = '0;
        win_we        = 1'b0;
        for (int i = 0; i < NumReq; i++) begin
            if (grant_vld && winner == PrioWidth'(i)) begin
                req_ready_o[i] = 1'b1;
                mem_addr_o     = req_addr_i[i*AddrWidth +: AddrWidth];
                mem_wr_data_o  = req_wdata_i[i*DataWidth +: DataWidth];
                win_we         = req_we_i[i];
                mem_we_o       = req_we_i[i];
            end
        end
    end

    assign rd_grant = grant_vld & ~win_we;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            prio_q      <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            if (grant_vld) begin
                prio_q <= prio_d;
            end
            rsp_valid_q <= rd_grant ? req_ready_o : '0;
            if (rd_grant) begin
                rsp_rdata_q <= mem_rd_data_i;
            end
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_spm_rr_arbiter.sv
// Bench for spm_rr_arbiter: a 2-requester instance with a memory model and a
// scoreboard, plus a 3-requester instance for pointer wrap-around.
module tb_spm_rr_arbiter;

    localparam int AW  = 10;
    localparam int DW  = 128;
    localparam int BAW = 4;
    localparam int BDW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic mem_clear;

    logic [1:0]      a_valid, a_ready, a_we, a_rsp_valid;
    logic [2*AW-1:0] a_addr;
    logic [2*DW-1:0] a_wdata;
    logic [DW-1:0]   a_rsp_rdata, a_mem_wdata, a_mem_rdata;
    logic [AW-1:0]   a_mem_addr;
    logic            a_mem_we;

    logic [2:0]       b_valid, b_ready, b_we, b_rsp_valid;
    logic [3*BAW-1:0] b_addr;
    logic [3*BDW-1:0] b_wdata;
    logic [BDW-1:0]   b_rsp_rdata, b_mem_wdata, b_mem_rdata;
    logic [BAW-1:0]   b_mem_addr;
    logic             b_mem_we;

    spm_rr_arbiter #(.NumReq(2), .DataWidth(DW), .DataDepth(1024)) dut_a (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(a_valid), .req_ready_o(a_ready), .req_we_i(a_we),
        .req_addr_i(a_addr), .req_wdata_i(a_wdata),
        .rsp_valid_o(a_rsp_valid), .rsp_rdata_o(a_rsp_rdata),
        .mem_addr_o(a_mem_addr), .mem_we_o(a_mem_we),
        .mem_wr_data_o(a_mem_wdata), .mem_rd_data_i(a_mem_rdata)
    );

    spm_rr_arbiter #(.NumReq(3), .DataWidth(BDW), .DataDepth(16)) dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(b_valid), .req_ready_o(b_ready), .req_we_i(b_we),
        .req_addr_i(b_addr), .req_wdata_i(b_wdata),
        .rsp_valid_o(b_rsp_valid), .rsp_rdata_o(b_rsp_rdata),
        .mem_addr_o(b_mem_addr), .mem_we_o(b_mem_we),
        .mem_wr_data_o(b_mem_wdata), .mem_rd_data_i(b_mem_rdata)
    );

    function automatic logic [DW-1:0] pat(input int i);
        return {32'(i) * 32'h9E37_79B1, ~32'(i), 32'(i), 32'hC0DE_0000 | 32'(i)};
    endfunction

    logic [DW-1:0] mem_a [1024];
    assign a_mem_rdata = mem_a[a_mem_addr];
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 1024; i++) mem_a[i] <= pat(i);
        end else if (a_mem_we) begin
            mem_a[a_mem_addr] <= a_mem_wdata;
        end
    end

    assign b_mem_rdata = {24'hB0B0B0, 4'h0, b_mem_addr};

    typedef struct {
        int            idx;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          q_a[$];
    logic [DW-1:0] ref_a [1024];
    logic [DW-1:0] last_a;
    logic [BDW-1:0] last_b;
    int  pa, pb, pend_b;
    bit  rsp_known;
    int  n_cmp = 0;
    int  n_bad = 0;

    function automatic int pred(input logic [2:0] v, input int p, input int n);
        for (int k = 0; k < n; k++) begin
            if (v[(p + k) % n]) return (p + k) % n;
        end
        return -1;
    endfunction

    // One cycle on instance a: check last edge's response, predict and check this grant, clock.
    task automatic step_a();
        rsp_t          e;
        int            w;
        logic [1:0]    exp_v, exp_rdy;
        logic [DW-1:0] exp_d, exp_wd;
        logic [AW-1:0] exp_addr;
        logic          exp_we;
        #1;
        if (rsp_known) begin
            exp_v = '0;
            exp_d = last_a;
            if (q_a.size() > 0) begin
                e      = q_a.pop_front();
                exp_v  = 2'(1 << e.idx);
                exp_d  = e.data;
                last_a = e.data;
            end
            n_cmp++;
            if (a_rsp_valid !== exp_v) begin
                n_bad++;
                $display("FAIL a_rsp_valid: got %b expected %b", a_rsp_valid, exp_v);
            end
            n_cmp++;
            if (a_rsp_rdata !== exp_d) begin
                n_bad++;
                $display("FAIL a_rsp_rdata: got %h expected %h", a_rsp_rdata, exp_d);
            end
        end
        w        = rst_n ? pred({1'b0, a_valid}, pa, 2) : -1;
        exp_rdy  = '0;
        exp_addr = '0;
        exp_we   = 1'b0;
        exp_wd   = '0;
        if (w >= 0) begin
            exp_rdy[w] = 1'b1;
            exp_addr   = a_addr[w*AW +: AW];
            exp_we     = a_we[w];
            exp_wd     = a_wdata[w*DW +: DW];
            if (exp_we) begin
                ref_a[exp_addr] = exp_wd;
            end else begin
                e.idx  = w;
                e.data = ref_a[exp_addr];
                q_a.push_back(e);
            end
            pa = (w + 1) % 2;
        end
        n_cmp++;
        if (a_ready !== exp_rdy) begin
            n_bad++;
            $display("FAIL a_ready: got %b expected %b", a_ready, exp_rdy);
        end
        n_cmp++;
        if (a_mem_addr !== exp_addr) begin
            n_bad++;
            $display("FAIL a_mem_addr: got %0d expected %0d", a_mem_addr, exp_addr);
        end
        n_cmp++;
        if (a_mem_we !== exp_we) begin
            n_bad++;
            $display("FAIL a_mem_we: got %b expected %b", a_mem_we, exp_we);
        end
        n_cmp++;
        if (a_mem_wdata !== exp_wd) begin
            n_bad++;
            $display("FAIL a_mem_wdata: got %h expected %h", a_mem_wdata, exp_wd);
        end
        @(posedge clk);
        if (!rst_n) begin
            q_a.delete();
            last_a    = '0;
            pa        = 0;
            rsp_known = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic step_b();
        int             w;
        logic [2:0]     exp_v, exp_rdy;
        logic [BDW-1:0] exp_d;
        logic [BAW-1:0] exp_addr;
        #1;
        exp_v = '0;
        exp_d = last_b;
        if (pend_b >= 0) begin
            exp_v  = 3'(1 << pend_b);
            exp_d  = {24'hB0B0B0, 4'h0, 4'(pend_b + 1)};
            last_b = exp_d;
        end
        n_cmp++;
        if (b_rsp_valid !== exp_v || b_rsp_rdata !== exp_d) begin
            n_bad++;
            $display("FAIL b_rsp: got %b/%h expected %b/%h", b_rsp_valid, b_rsp_rdata, exp_v, exp_d);
        end
        w        = pred(b_valid, pb, 3);
        exp_rdy  = '0;
        exp_addr = '0;
        if (w >= 0) begin
            exp_rdy[w] = 1'b1;
            exp_addr   = b_addr[w*BAW +: BAW];
            pb         = (w + 1) % 3;
        end
        pend_b = w;
        n_cmp++;
        if (b_ready !== exp_rdy || b_mem_addr !== exp_addr) begin
            n_bad++;
            $display("FAIL b_grant: got %b/%0d expected %b/%0d", b_ready, b_mem_addr, exp_rdy, exp_addr);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        a_valid = 2'b11;
        a_we    = 2'b11;
        a_addr  = {10'd7, 10'd7};
        a_wdata = {2{128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF}};
        b_valid = 3'b111;
        #1;
        n_cmp++;
        if (b_ready !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_b_ready: got %b expected 000", b_ready);
        end
        step_a();
        mem_clear = 1'b0;
        step_a();
        rst_n   = 1'b1;
        b_valid = 3'b000;
        a_we    = 2'b00;
        #1;
        n_cmp++;
        if (a_ready !== 2'b01) begin
            n_bad++;
            $display("FAIL reset_first_grant: got %b expected 01", a_ready);
        end
        step_a();
        a_valid = 2'b00;
        step_a();
    endtask

    task automatic test_contention();
        for (int c = 0; c < 6; c++) begin
            a_valid = 2'b11;
            a_we    = 2'b00;
            a_addr  = {AW'(200 + c), AW'(100 + c)};
            step_a();
        end
        a_valid = 2'b00;
        step_a();
    endtask

    task automatic test_raw();
        a_valid = 2'b01;
        a_we    = 2'b01;
        a_addr  = {10'd0, 10'd5};
        a_wdata = {128'h0, {16{8'hA5}}};
        step_a();
        a_valid = 2'b10;
        a_we    = 2'b00;
        a_addr  = {10'd5, 10'd0};
        step_a();
        n_cmp++;
        if (a_rsp_valid !== 2'b10 || a_rsp_rdata !== {16{8'hA5}}) begin
            n_bad++;
            $display("FAIL raw: got %b/%h expected 10/%h", a_rsp_valid, a_rsp_rdata, {16{8'hA5}});
        end
        a_valid = 2'b00;
        step_a();
    endtask

    task automatic test_idle();
        a_valid = 2'b01;
        a_we    = 2'b00;
        a_addr  = {10'd9, 10'd5};
        step_a();
        a_valid = 2'b00;
        a_we    = 2'b11;
        for (int c = 0; c < 5; c++) begin
            step_a();
            n_cmp++;
            if (a_rsp_rdata !== {16{8'hA5}}) begin
                n_bad++;
                $display("FAIL idle_hold: got %h expected %h", a_rsp_rdata, {16{8'hA5}});
            end
        end
        a_valid = 2'b11;
        a_we    = 2'b00;
        #1;
        n_cmp++;
        if (a_ready !== 2'b10) begin
            n_bad++;
            $display("FAIL idle_next_grant: got %b expected 10", a_ready);
        end
        step_a();
        a_valid = 2'b00;
        step_a();
    endtask

    task automatic test_reset_mid();
        a_valid = 2'b01;
        a_we    = 2'b00;
        a_addr  = {10'd0, 10'd100};
        step_a();
        rst_n   = 1'b0;
        a_valid = 2'b00;
        step_a();
        rst_n   = 1'b1;
        a_valid = 2'b11;
        n_cmp++;
        if (a_rsp_valid !== 2'b00 || a_rsp_rdata !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_rsp: got %b/%h expected 00/0", a_rsp_valid, a_rsp_rdata);
        end
        #1;
        n_cmp++;
        if (a_ready !== 2'b01) begin
            n_bad++;
            $display("FAIL reset_mid_prio: got %b expected 01", a_ready);
        end
        step_a();
        a_valid = 2'b00;
        step_a();
    endtask

    task automatic test_wrap();
        b_valid = 3'b111;
        for (int k = 0; k < 9; k++) begin
            #1;
            n_cmp++;
            if (b_ready !== 3'(1 << (k % 3))) begin
                n_bad++;
                $display("FAIL wrap_order[%0d]: got %b expected %b", k, b_ready, 3'(1 << (k % 3)));
            end
            step_b();
        end
        b_valid = 3'b100;
        #1;
        n_cmp++;
        if (b_ready !== 3'b100) begin
            n_bad++;
            $display("FAIL wrap_only_req2: got %b expected 100", b_ready);
        end
        step_b();
        b_valid = 3'b000;
        step_b();
    endtask

    initial begin
        rst_n     = 1'b0;
        mem_clear = 1'b1;
        rsp_known = 1'b0;
        a_valid   = '0;
        a_we      = '0;
        a_addr    = '0;
        a_wdata   = '0;
        b_valid   = '0;
        b_we      = '0;
        b_addr    = {4'd3, 4'd2, 4'd1};
        b_wdata   = '0;
        last_a    = '0;
        last_b    = '0;
        pa        = 0;
        pb        = 0;
        pend_b    = -1;
        for (int i = 0; i < 1024; i++) ref_a[i] = pat(i);
        @(negedge clk);
        test_reset();
        test_contention();
        test_raw();
        test_idle();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
